// File: rtl/pipe_muldiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_muldiv_pkg - shared state/op encodings for the mul/div controller   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pipe_muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITER - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Magnitude; 32'h80000000 maps to itself and is then treated as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_iter - one radix-2 shift/add (mul) or restoring-subtract (div)    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module muldiv_iter (
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  input  logic        is_div,
  output logic [63:0] acc_next
);

  logic [32:0] w_sum;
  logic [31:0] w_diff;
  logic        w_take;

  always_comb begin
    w_sum  = {1'b0, acc[63:32]} + {1'b0, operand};
    // Shifted partial remainder is acc[63:31]; bit 63 set means it already exceeds any divisor.
    w_diff = acc[62:31] - operand;
    w_take = acc[63] | (acc[62:31] >= operand);
    acc_next = {1'b0, acc[63:1]};
    if (is_div) begin
      if (w_take) acc_next = {w_diff, acc[30:0], 1'b1};
      else        acc_next = {acc[62:0], 1'b0};
    end else if (acc[0]) begin
      acc_next = {w_sum, acc[31:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_muldiv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_muldiv_ctrl - iterative MULT/DIV controller owning HI/LO and stall  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipe_muldiv_ctrl
  import pipe_muldiv_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hi,
  input  logic        rd_lo,
  input  logic        wr_hi,
  input  logic        wr_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        mstall,
  output logic        done
);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic             r_sa;
  logic             r_sb;
  logic             r_div0;
  logic             r_done;
  logic [63:0]      r_acc;
  logic [63:0]      w_acc_next;
  logic [31:0]      r_opnd;
  logic             w_signed;
  logic             w_is_div;
  logic [63:0]      w_prod;
  logic [31:0]      w_quot;
  logic [31:0]      w_rem;
  logic [31:0]      w_hi_res;
  logic [31:0]      w_lo_res;

  muldiv_iter u_iter (
    .acc      (r_acc),
    .operand  (r_opnd),
    .is_div   (w_is_div),
    .acc_next (w_acc_next)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_CALC;
      ST_CALC: if (r_cnt == '0) w_next_state = ST_FIX;
      ST_FIX:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state != ST_IDLE);
    mstall = busy & (start | rd_hi | rd_lo | wr_hi | wr_lo);
    done   = r_done;
  end

  always_comb begin
    w_signed = op_is_signed(r_op);
    w_is_div = op_is_div(r_op);
    w_prod   = (w_signed && (r_sa ^ r_sb)) ? (~r_acc + 64'd1) : r_acc;
    // Divide-by-zero leaves quotient all ones and remainder |a|; re-signing the
    // remainder by sa restores the original a.
    w_quot   = (w_signed && (r_sa ^ r_sb) && !r_div0) ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    w_rem    = (w_signed && r_sa) ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
    w_hi_res = w_is_div ? w_rem  : w_prod[63:32];
    w_lo_res = w_is_div ? w_quot : w_prod[31:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= '0;
      r_op   <= OP_MULT;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_div0 <= 1'b0;
      r_done <= 1'b0;
      r_acc  <= '0;
      r_opnd <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op   <= op;
            r_sa   <= a[31];
            r_sb   <= b[31];
            r_div0 <= (b == 32'd0);
            r_acc  <= {32'd0, abs32(a, op_is_signed(op))};
            r_opnd <= abs32(b, op_is_signed(op));
            r_cnt  <= CNT_INIT;
          end else begin
            if (wr_hi) hi <= a;
            if (wr_lo) lo <= a;
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_next;
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        ST_FIX: begin
          hi     <= w_hi_res;
          lo     <= w_lo_res;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_muldiv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_muldiv_ctrl - directed-vector bench for pipe_muldiv_ctrl         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pipe_muldiv_ctrl;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        rd_hi = 1'b0;
  logic        rd_lo = 1'b0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        mstall;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  pipe_muldiv_ctrl dut (
    .clock(clock), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .rd_hi(rd_hi), .rd_lo(rd_lo), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .hi(hi), .lo(lo), .busy(busy), .mstall(mstall), .done(done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Returns one step after the start edge with start deasserted.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) step();
    vectors++;
    if ({hi, lo, busy, done, mstall} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b mstall=%b, want all zero", hi, lo, busy, done, mstall);
    end
    @(negedge clock);
    resetn = 1'b1;
    step();
    rd_hi = 1'b1; rd_lo = 1'b1;
    #1;
    vectors++;
    if (mstall !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_read_no_stall: got mstall=%b, want 0", mstall);
    end
    rd_hi = 1'b0; rd_lo = 1'b0;
  endtask

  task automatic test_mult_timing();
    int bad = 0;
    issue(MULT, 32'hFFFFFFFD, 32'd5);
    for (int i = 0; i < 33; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      step();
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL mult_busy_window: got %0d bad cycles, want 0", bad);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mult_done_k34: got done=%b busy=%b, want done=1 busy=0", done, busy);
    end
    vectors++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin
      miscompares++;
      $display("FAIL mult_result: got %h_%h, want ffffffff_fffffff1", hi, lo);
    end
    step();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL mult_done_pulse: got done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_arith();
    int lat;
    vec_t tbl [7] = '{
      '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
      '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD},
      '{DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E},
      '{DIVU,  32'd1234,     32'd0,        32'h000004D2, 32'hFFFFFFFF},
      '{DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
      '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
      '{DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF}
    };
    for (int i = 0; i < 7; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_done(lat);
      vectors++;
      if (lat != 33) begin
        miscompares++;
        $display("FAIL arith_latency[%0d]: got %0d edges, want 33", i, lat);
      end
      vectors++;
      if (hi !== tbl[i].hi || lo !== tbl[i].lo) begin
        miscompares++;
        $display("FAIL arith_result[%0d]: got hi=%h lo=%h, want hi=%h lo=%h", i, hi, lo, tbl[i].hi, tbl[i].lo);
      end
      step();
    end
  endtask

  task automatic test_mflo_stall();
    int bad = 0;
    issue(MULT, 32'hFFFFFFFE, 32'd3);
    rd_lo = 1'b1;
    #1;
    for (int i = 0; i < 33; i++) begin
      if (mstall !== 1'b1) bad++;
      step();
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL mflo_stall_window: got %0d unstalled cycles, want 0", bad);
    end
    vectors++;
    if (mstall !== 1'b0 || lo !== 32'hFFFFFFFA) begin
      miscompares++;
      $display("FAIL mflo_release: got mstall=%b lo=%h, want mstall=0 lo=fffffffa", mstall, lo);
    end
    rd_lo = 1'b0;
    step();
  endtask

  task automatic test_mthi_stall();
    int bad = 0;
    issue(MULTU, 32'd3, 32'd4);
    a = 32'hCAFE0001; wr_hi = 1'b1;
    #1;
    for (int i = 0; i < 33; i++) begin
      if (mstall !== 1'b1) bad++;
      step();
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL mthi_stall_window: got %0d unstalled cycles, want 0", bad);
    end
    vectors++;
    if (hi !== 32'd0 || lo !== 32'd12 || mstall !== 1'b0) begin
      miscompares++;
      $display("FAIL mthi_held: got hi=%h lo=%h mstall=%b, want hi=0 lo=c mstall=0", hi, lo, mstall);
    end
    step();
    wr_hi = 1'b0;
    vectors++;
    if (hi !== 32'hCAFE0001) begin
      miscompares++;
      $display("FAIL mthi_applied: got hi=%h, want cafe0001", hi);
    end
  endtask

  task automatic test_move_idle();
    a = 32'h12345678; wr_lo = 1'b1;
    step();
    a = 32'h9ABCDEF0; wr_lo = 1'b0; wr_hi = 1'b1;
    step();
    wr_hi = 1'b0;
    vectors++;
    if (hi !== 32'h9ABCDEF0 || lo !== 32'h12345678) begin
      miscompares++;
      $display("FAIL mt_idle: got hi=%h lo=%h, want 9abcdef0 12345678", hi, lo);
    end
  endtask

  task automatic test_start_priority();
    int lat;
    wr_lo = 1'b1;
    issue(MULTU, 32'd5, 32'd5);
    wr_lo = 1'b0;
    vectors++;
    if (lo !== 32'h12345678) begin
      miscompares++;
      $display("FAIL start_priority_drop: got lo=%h, want 12345678", lo);
    end
    wait_done(lat);
    vectors++;
    if (lo !== 32'd25 || hi !== 32'd0) begin
      miscompares++;
      $display("FAIL start_priority_result: got hi=%h lo=%h, want 0 19", hi, lo);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(MULTU, 32'd2, 32'd3);
    op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    repeat (33) step();
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || mstall !== 1'b0 || lo !== 32'd6) begin
      miscompares++;
      $display("FAIL b2b_first: got done=%b busy=%b mstall=%b lo=%h, want 1 0 0 6", done, busy, mstall, lo);
    end
    step();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: got busy=%b, want 1", busy);
    end
    wait_done(lat);
    vectors++;
    if (lat != 33 || hi !== 32'd2 || lo !== 32'd14) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d hi=%h lo=%h, want 33 2 e", lat, hi, lo);
    end
    step();
  endtask

  task automatic test_reset_abort();
    int lat;
    issue(DIV, 32'hFFFFFF9C, 32'd3);
    rd_hi = 1'b1;
    repeat (9) step();
    #2;
    resetn = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || mstall !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_abort: got busy=%b mstall=%b done=%b hi=%h lo=%h, want all zero", busy, mstall, done, hi, lo);
    end
    rd_hi = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    step();
    issue(MULTU, 32'd6, 32'd7);
    wait_done(lat);
    vectors++;
    if (lat != 33 || lo !== 32'h0000002A || hi !== 32'd0) begin
      miscompares++;
      $display("FAIL post_reset_multu: got lat=%0d hi=%h lo=%h, want 33 0 2a", lat, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult_timing();
    test_arith();
    test_mflo_stall();
    test_mthi_stall();
    test_move_idle();
    test_start_priority();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
